// File: rtl/result_sel_pkg.sv
// Shared types and constants for the N-way result-select stage.
// Source indices match the writeback mux ordering of the RISC-V datapath.
`timescale 1ns/1ps
package result_sel_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_N     = 4;
  localparam int DEF_ERRW  = 8;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

endpackage

// File: rtl/result_sel_pipe_skid_buf.sv
// Two-entry valid/ready skid buffer carrying an opaque payload.
// in_ready is a flop, so the producer never sees a combinational path from out_ready.
`timescale 1ns/1ps
module skid_buf
  import result_sel_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_payload,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_payload,
  output logic          out_valid,
  input  logic          out_ready
);

  state_e        state_reg, state_next;
  logic [DW-1:0] main_reg, main_next;
  logic [DW-1:0] skid_reg, skid_next;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          accept;
  logic          deliver;

  assign accept  = in_valid && in_ready_reg;
  assign deliver = out_valid_reg && out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          main_next  = in_payload;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && deliver) begin
          main_next = in_payload;
        end else if (accept) begin
          skid_next  = in_payload;
          state_next = ST_FULL;
        end else if (deliver) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain path exists
        if (deliver) begin
          main_next  = skid_reg;
          state_next = ST_BUSY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      main_reg      <= '0;
      skid_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      in_ready_reg  <= (state_next != ST_FULL);
      out_valid_reg <= (state_next != ST_EMPTY);
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_payload = main_reg;

endmodule

// File: rtl/result_sel_pipe.sv
// Registered N-way result select with valid/ready handshake between execute and writeback.
// Out-of-range selects yield zero data and are tallied in a sticky flag and saturating counter.
`timescale 1ns/1ps
module result_sel_pipe
  import result_sel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N,
  parameter int ERRW  = DEF_ERRW,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err,
  output logic [ERRW-1:0]    err_cnt,
  input  logic               err_clr
);

  localparam int             DW  = SELW + WIDTH;
  localparam logic [SELW:0]  N_L = (SELW+1)'(N);

  logic [SELW:0]    sel_wide;
  logic             sel_ok;
  logic [WIDTH-1:0] hit_data [N];
  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic [DW-1:0]    out_payload;
  logic             sel_err_reg;
  logic [ERRW-1:0]  err_cnt_reg;

  assign sel_wide = {1'b0, sel};
  assign sel_ok   = (sel_wide < N_L);

  // One-hot AND-OR mux: an illegal index matches no source and falls out as zero
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_src
      assign hit_data[gi] = (sel_wide == (SELW+1)'(gi)) ? in_data[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      sel_data = sel_data | hit_data[k];
    end
  end

  skid_buf #(
    .DW (DW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_payload  ({sel, sel_data}),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_payload (out_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  assign out_sel  = out_payload[DW-1 -: SELW];
  assign out_data = out_payload[WIDTH-1:0];
  assign accept   = in_valid && in_ready;

  // Clear has priority over a coincident illegal accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else if (err_clr) begin
      sel_err_reg <= 1'b0;
      err_cnt_reg <= '0;
    end else if (accept && !sel_ok) begin
      sel_err_reg <= 1'b1;
      if (err_cnt_reg != {ERRW{1'b1}}) begin
        err_cnt_reg <= err_cnt_reg + ERRW'(1);
      end
    end
  end

  assign sel_err = sel_err_reg;
  assign err_cnt = err_cnt_reg;

endmodule
